link_channel_scheduler: RTL and testbench

// - Shares one inter-FPGA link between NUM_CHANNELS PU arbitration units.
// - Egress: round-robin arbiter with a registered output stage; merges the channels' outgoing

---
 rtl/link_sched_pkg.sv | 25 ++
 rtl/rr_grant_select.sv | 43 ++++
 rtl/link_channel_scheduler.sv | 163 ++++++++++++++++
 tb/tb_link_channel_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/link_sched_pkg.sv
// Shared definitions for the link channel scheduler.
//   - default parameter values for the scheduler
//   - ch_idx_width(): width of a channel index for a given channel count
//   - hdr_lsb(): bit offset of the header field inside a link word
//   - link_word_t: link word at the default width
package link_sched_pkg;

  localparam int unsigned DEF_NUM_CHANNELS     = 4;
  localparam int unsigned DEF_FINAL_FIFO_WIDTH = 32;
  localparam int unsigned DEF_HEADER_WIDTH     = 4;
  localparam int unsigned DEF_IDLE_CYCLES      = 8;

  typedef logic [DEF_FINAL_FIFO_WIDTH-1:0] link_word_t;

  // A single-channel index still needs one bit to exist as a signal.
  function automatic int unsigned ch_idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // The header sits in the top bits of the word.
  function automatic int unsigned hdr_lsb(input int unsigned w, input int unsigned h);
    return w - h;
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Combinational round-robin grant search.
//   valid     in   N   request vector
//   ptr       in   IW  highest-priority position for this search
//   grant     out  N   one-hot grant (all zero when nothing is valid)
//   grant_idx out  IW  index of the granted request
//   any       out  1   a grant was found
// The request vector is replicated to 2N bits and the positions below ptr in
// the lower copy are masked off; the first set bit of the result is the
// winner, and its position modulo N is the granted channel.
module rr_grant_select
  import link_sched_pkg::*;
#(
  parameter int unsigned N  = DEF_NUM_CHANNELS,
  parameter int unsigned IW = ch_idx_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [2*N-1:0] masked;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    masked    = {valid, valid};
    grant_idx = '0;
    any       = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      if (j < int'(ptr)) masked[j] = 1'b0;
    end
    for (int j = 0; j < 2 * int'(N); j++) begin
      if (!any && masked[j]) begin
        any       = 1'b1;
        grant_idx = (j >= int'(N)) ? IW'(j - int'(N)) : IW'(j);
      end
    end
    grant = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/link_channel_scheduler.sv
// Shares one inter-FPGA link between NUM_CHANNELS arbitration units.
//   clk            in   single clock, rising edge
//   reset          in   asynchronous, active-low
//   ch_out_data    in   N*W  channel i egress word at [i*W +: W]
//   ch_out_valid   in   N    channel i has a word for the link
//   ch_out_ready   out  N    one-hot egress grant
//   link_out_data  out  W    registered egress word
//   link_out_valid out  1    egress register full
//   link_out_ready in   1    link accepts word
//   link_in_data   in   W    ingress word from link
//   link_in_valid  in   1    ingress word present
//   link_in_ready  out  1    ingress register can accept
//   ch_in_data     out  N*W  held ingress word, broadcast to all channels
//   ch_in_valid    out  N    one-hot: held word is for channel i
//   ch_in_ready    in   N    channel i accepts
//   ch_busy        in   N    channel i has messages in flight
//   all_idle       out  1    system quiet for IDLE_CYCLES cycles
//   route_error    out  1    sticky: a word arrived for a nonexistent channel
module link_channel_scheduler
  import link_sched_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS     = DEF_NUM_CHANNELS,
  parameter int unsigned FINAL_FIFO_WIDTH = DEF_FINAL_FIFO_WIDTH,
  parameter int unsigned HEADER_WIDTH     = DEF_HEADER_WIDTH,
  parameter int unsigned IDLE_CYCLES      = DEF_IDLE_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS*FINAL_FIFO_WIDTH-1:0] ch_out_data,
  input  logic [NUM_CHANNELS-1:0]                ch_out_valid,
  output logic [NUM_CHANNELS-1:0]                ch_out_ready,
  output logic [FINAL_FIFO_WIDTH-1:0]            link_out_data,
  output logic                                   link_out_valid,
  input  logic                                   link_out_ready,
  input  logic [FINAL_FIFO_WIDTH-1:0]            link_in_data,
  input  logic                                   link_in_valid,
  output logic                                   link_in_ready,
  output logic [NUM_CHANNELS*FINAL_FIFO_WIDTH-1:0] ch_in_data,
  output logic [NUM_CHANNELS-1:0]                ch_in_valid,
  input  logic [NUM_CHANNELS-1:0]                ch_in_ready,
  input  logic [NUM_CHANNELS-1:0]                ch_busy,
  output logic                                   all_idle,
  output logic                                   route_error
);

  localparam int unsigned N       = NUM_CHANNELS;
  localparam int unsigned W       = FINAL_FIFO_WIDTH;
  localparam int unsigned IW      = ch_idx_width(N);
  localparam int unsigned HDR_LSB = hdr_lsb(W, HEADER_WIDTH);
  localparam int unsigned CNT_W   = $clog2(IDLE_CYCLES + 1);

  // ---------------------------------------------------------------- egress
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [IW-1:0] rr_ptr;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic          egress_load;
  logic          egress_take;
  logic [W-1:0]  sel_word;

  rr_grant_select #(.N(N), .IW(IW)) u_grant (
    .valid     (ch_out_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign egress_load = !out_valid || link_out_ready;
  // Handshakes are refused while reset is held: the registers cannot
  // capture then, so an accepted word would be lost.
  assign ch_out_ready = (reset && egress_load) ? grant : '0;
  assign egress_take  = reset && egress_load && grant_any;

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant[i]) sel_word = ch_out_data[i*W +: W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (egress_take) begin
      out_valid <= 1'b1;
      out_data  <= sel_word;
      rr_ptr    <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end else if (link_out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign link_out_data  = out_data;
  assign link_out_valid = out_valid;

  // --------------------------------------------------------------- ingress
  logic [W-1:0]            hold_data;
  logic                    hold_valid;
  logic [IW-1:0]           dest;
  logic [HEADER_WIDTH-1:0] in_hdr;
  logic                    in_bad;
  logic                    in_take;

  assign dest   = hold_data[HDR_LSB +: IW];
  assign in_hdr = link_in_data[W-1 -: HEADER_WIDTH];
  // The whole header is compared so that e.g. id 4 never aliases channel 0.
  assign in_bad = 32'(in_hdr) >= N;

  assign link_in_ready = reset && (!hold_valid || ch_in_ready[dest]);
  assign in_take       = link_in_valid && link_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      route_error <= 1'b0;
    end else if (in_take) begin
      // Accepting implies the held word (if any) drains this cycle.
      hold_valid <= !in_bad;
      if (in_bad) route_error <= 1'b1;
      else        hold_data   <= link_in_data;
    end else if (hold_valid && ch_in_ready[dest]) begin
      hold_valid <= 1'b0;
    end
  end

  assign ch_in_valid = hold_valid ? (N'(1) << dest) : '0;
  assign ch_in_data  = {N{hold_data}};

  // ---------------------------------------------------------- idle detector
  logic             quiet;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_cnt_next;

  assign quiet = !(|ch_busy) && !(|ch_out_valid) && !link_in_valid
                 && !out_valid && !hold_valid;

  always_comb begin
    if (!quiet)                                  idle_cnt_next = '0;
    else if (idle_cnt == CNT_W'(IDLE_CYCLES))    idle_cnt_next = idle_cnt;
    else                                         idle_cnt_next = idle_cnt + 1'b1;
  end

  // all_idle is the registered form of (idle_cnt == IDLE_CYCLES), so it
  // drops in the cycle right after any busy cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      all_idle <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_next;
      all_idle <= (idle_cnt_next == CNT_W'(IDLE_CYCLES));
    end
  end

endmodule

// File: tb/tb_link_channel_scheduler.sv
module tb_link_channel_scheduler;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic [N*W-1:0] ch_out_data;
  logic [N-1:0]   ch_out_valid;
  logic [N-1:0]   ch_out_ready;
  logic [W-1:0]   link_out_data;
  logic           link_out_valid;
  logic           link_out_ready;
  logic [W-1:0]   link_in_data;
  logic           link_in_valid;
  logic           link_in_ready;
  logic [N*W-1:0] ch_in_data;
  logic [N-1:0]   ch_in_valid;
  logic [N-1:0]   ch_in_ready;
  logic [N-1:0]   ch_busy;
  logic           all_idle;
  logic           route_error;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] d [N];
  logic [W-1:0] wa, wb, wc, wd, we;

  link_channel_scheduler #(
    .NUM_CHANNELS(N), .FINAL_FIFO_WIDTH(W), .HEADER_WIDTH(4), .IDLE_CYCLES(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ch_out_data    (ch_out_data),
    .ch_out_valid   (ch_out_valid),
    .ch_out_ready   (ch_out_ready),
    .link_out_data  (link_out_data),
    .link_out_valid (link_out_valid),
    .link_out_ready (link_out_ready),
    .link_in_data   (link_in_data),
    .link_in_valid  (link_in_valid),
    .link_in_ready  (link_in_ready),
    .ch_in_data     (ch_in_data),
    .ch_in_valid    (ch_in_valid),
    .ch_in_ready    (ch_in_ready),
    .ch_busy        (ch_busy),
    .all_idle       (all_idle),
    .route_error    (route_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d[0] = 32'hA000_0010; d[1] = 32'hA111_0011;
    d[2] = 32'hA222_0012; d[3] = 32'hA333_0013;
    wa = {4'h2, 28'h00000A5};
    wb = {4'h0, 28'h00000B6};
    wc = {4'h4, 28'h00000C7};
    wd = {4'hF, 28'h00000D8};
    we = {4'h1, 28'h00000E9};

    reset          = 1'b0;
    ch_out_data    = {d[3], d[2], d[1], d[0]};
    ch_out_valid   = '0;
    link_out_ready = 1'b0;
    link_in_data   = '0;
    link_in_valid  = 1'b0;
    ch_in_ready    = '0;
    ch_busy        = '0;

    // ---- reset state
    tick(); tick();
    check("rst_out_valid", 128'(link_out_valid), 128'(0));
    check("rst_out_data",  128'(link_out_data),  128'(0));
    check("rst_ch_in_valid", 128'(ch_in_valid),  128'(0));
    check("rst_all_idle",  128'(all_idle),       128'(0));
    check("rst_route_err", 128'(route_error),    128'(0));
    reset = 1'b1;

    // ---- idle detector: 8 quiet cycles, then a busy pulse restarts the count
    for (int i = 0; i < 7; i++) tick();
    check("idle_after7", 128'(all_idle), 128'(0));
    tick();
    check("idle_after8", 128'(all_idle), 128'(1));
    ch_busy = 4'b0010;
    tick();
    check("idle_busy_drop", 128'(all_idle), 128'(0));
    ch_busy = 4'b0000;
    for (int i = 0; i < 7; i++) tick();
    check("idle_re7", 128'(all_idle), 128'(0));
    tick();
    check("idle_re8", 128'(all_idle), 128'(1));

    // ---- egress: all channels valid, link always ready
    ch_out_valid   = 4'hF;
    link_out_ready = 1'b1;
    #1;
    check("rr_first_ready", 128'(ch_out_ready), 128'(4'b0001));
    check("rr_first_ovalid", 128'(link_out_valid), 128'(0));
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr_data_%0d", k), 128'(link_out_data), 128'(d[k % 4]));
      check($sformatf("rr_valid_%0d", k), 128'(link_out_valid), 128'(1));
      check($sformatf("rr_ready_%0d", k), 128'(ch_out_ready), 128'(4'b0001 << ((k + 1) % 4)));
    end
    check("busy_no_idle", 128'(all_idle), 128'(0));

    // ---- egress: only channels 1 and 3, pointer now at 2
    ch_out_valid = 4'b1010;
    #1;
    check("sp_grant3", 128'(ch_out_ready), 128'(4'b1000));
    tick();
    check("sp_data3", 128'(link_out_data), 128'(d[3]));
    check("sp_grant1", 128'(ch_out_ready), 128'(4'b0010));
    tick();
    check("sp_data1", 128'(link_out_data), 128'(d[1]));
    link_out_ready = 1'b0;
    #1;
    check("stall_no_grant", 128'(ch_out_ready), 128'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall_data_%0d", k), 128'(link_out_data), 128'(d[1]));
      check($sformatf("stall_valid_%0d", k), 128'(link_out_valid), 128'(1));
      check($sformatf("stall_ready_%0d", k), 128'(ch_out_ready), 128'(0));
    end
    link_out_ready = 1'b1;
    #1;
    check("resume_grant3", 128'(ch_out_ready), 128'(4'b1000));
    tick();
    check("resume_data3", 128'(link_out_data), 128'(d[3]));
    ch_out_valid = 4'b0000;
    tick();
    check("drain_valid", 128'(link_out_valid), 128'(0));

    // ---- ingress: header 2 held while channel 2 stalls, then header 0
    ch_in_ready   = 4'b1011;
    link_in_data  = wa;
    link_in_valid = 1'b1;
    #1;
    check("in_ready_empty", 128'(link_in_ready), 128'(1));
    tick();
    link_in_data = wb;
    #1;
    check("in_valid_ch2", 128'(ch_in_valid), 128'(4'b0100));
    check("in_data_ch0", 128'(ch_in_data[31:0]), 128'(wa));
    check("in_data_ch2", 128'(ch_in_data[95:64]), 128'(wa));
    check("in_ready_block", 128'(link_in_ready), 128'(0));
    tick();
    check("in_hold_ch2", 128'(ch_in_valid), 128'(4'b0100));
    check("in_hold_block", 128'(link_in_ready), 128'(0));
    ch_in_ready = 4'b1111;
    #1;
    check("in_ready_drain", 128'(link_in_ready), 128'(1));
    tick();
    link_in_valid = 1'b0;
    #1;
    check("in_valid_ch0", 128'(ch_in_valid), 128'(4'b0001));
    check("in_data_b", 128'(ch_in_data[127:96]), 128'(wb));
    tick();
    check("in_empty", 128'(ch_in_valid), 128'(0));
    check("in_no_err", 128'(route_error), 128'(0));

    // ---- bad headers: 4 (low bits alias channel 0) and F
    link_in_data  = wc;
    link_in_valid = 1'b1;
    #1;
    check("bad4_ready", 128'(link_in_ready), 128'(1));
    tick();
    link_in_valid = 1'b0;
    #1;
    check("bad4_dropped", 128'(ch_in_valid), 128'(0));
    check("bad4_err", 128'(route_error), 128'(1));
    link_in_data  = wd;
    link_in_valid = 1'b1;
    tick();
    link_in_valid = 1'b0;
    tick();
    check("badF_dropped", 128'(ch_in_valid), 128'(0));
    check("badF_err_sticky", 128'(route_error), 128'(1));

    // ---- reset with both registers full
    ch_out_valid   = 4'hF;
    link_out_ready = 1'b0;
    ch_in_ready    = 4'b0000;
    link_in_data   = we;
    link_in_valid  = 1'b1;
    tick();
    link_in_valid = 1'b0;
    #1;
    check("pre_rst_ovalid", 128'(link_out_valid), 128'(1));
    check("pre_rst_odata", 128'(link_out_data), 128'(d[0]));
    check("pre_rst_ivalid", 128'(ch_in_valid), 128'(4'b0010));
    reset = 1'b0;
    #1;
    check("arst_ovalid", 128'(link_out_valid), 128'(0));
    check("arst_odata", 128'(link_out_data), 128'(0));
    check("arst_ivalid", 128'(ch_in_valid), 128'(0));
    check("arst_idata", 128'(ch_in_data), 128'(0));
    check("arst_err", 128'(route_error), 128'(0));
    check("arst_oready", 128'(ch_out_ready), 128'(0));
    check("arst_iready", 128'(link_in_ready), 128'(0));
    tick();
    reset          = 1'b1;
    link_out_ready = 1'b1;
    #1;
    check("post_rst_grant0", 128'(ch_out_ready), 128'(4'b0001));
    tick();
    check("post_rst_data0", 128'(link_out_data), 128'(d[0]));
    check("post_rst_valid", 128'(link_out_valid), 128'(1));
    check("post_rst_grant1", 128'(ch_out_ready), 128'(4'b0010));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
